// File: rtl/sigma_delta_pkg.sv
// Width helpers and shared types for the sigma-delta ADC slice.
package sigma_delta_pkg;

  localparam int DEF_OVERSAMPLE_RATE = 256;
  localparam int DEF_CIC_STAGES      = 2;
  localparam int DEF_ADC_BITLEN      = 16;

  function automatic int cic_log2(input int r);
    return $clog2(r);
  endfunction

  function automatic int cic_width(input int r, input int n);
    return n * $clog2(r) + 1;
  endfunction

  // Positive result: right shift of the clamped CIC word; negative: left shift.
  function automatic int cic_shift(input int r, input int n, input int bitlen);
    return n * $clog2(r) - bitlen;
  endfunction

  typedef logic [cic_width(DEF_OVERSAMPLE_RATE, DEF_CIC_STAGES)-1:0] cic_word_t;

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: difference against the value held at the previous enable.
module cic_comb #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dly <= '0;
    else if (ena)
      dly <= din;
  end

  assign dout = din - dly;

endmodule

// File: rtl/cic_integrator.sv
// One CIC integrator stage; modular accumulation, wrap-around is intentional.
module cic_integrator #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dout <= '0;
    else if (ena)
      dout <= dout + din;
  end

endmodule

// File: rtl/sigma_delta_sync.sv
// Two-flop synchronizer for the asynchronous comparator input.
module sigma_delta_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// Fabric sigma-delta ADC: comparator sampling, 1-bit feedback, N-stage CIC decimator.
// Optional macro SIGMA_DELTA_ADC_SETTLE_MASK_EN hides the first N+1 transient samples.
module sigma_delta_adc
  import sigma_delta_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = DEF_OVERSAMPLE_RATE,
  parameter int CIC_STAGES      = DEF_CIC_STAGES,
  parameter int ADC_BITLEN      = DEF_ADC_BITLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_cmp_in,
  output logic                  adc_fb_pin,
  output logic [ADC_BITLEN-1:0] adc_data,
  output logic                  adc_valid,
  input  logic                  adc_ready,
  output logic                  adc_overrun
);

  localparam int L     = cic_log2(OVERSAMPLE_RATE);
  localparam int NL    = CIC_STAGES * L;
  localparam int CIC_W = cic_width(OVERSAMPLE_RATE, CIC_STAGES);
  localparam int SHIFT = cic_shift(OVERSAMPLE_RATE, CIC_STAGES, ADC_BITLEN);

  logic                             cmp_sync;
  logic                             bs;
  logic [L-1:0]                     cnt;
  logic                             dec_stb;
  logic                             stb_d;
  logic [CIC_STAGES:0][CIC_W-1:0]   integ;
  logic [CIC_STAGES:0][CIC_W-1:0]   comb;
  logic [CIC_W-1:0]                 cic_q;
  logic [NL-1:0]                    sat;
  logic [ADC_BITLEN-1:0]            scaled;
  logic                             masked;
  logic                             new_sample;

  sigma_delta_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (adc_cmp_in),
    .q   (cmp_sync)
  );

  // bs is the third register after the pin and directly drives the feedback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bs <= 1'b0;
    else
      bs <= cmp_sync;
  end

  assign adc_fb_pin = bs;
  assign integ[0]   = CIC_W'(bs);

  for (genvar i = 0; i < CIC_STAGES; i++) begin : g_integ
    cic_integrator #(.W(CIC_W)) u_int (
      .clk  (clk),
      .rst  (rst),
      .ena  (1'b1),
      .din  (integ[i]),
      .dout (integ[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign dec_stb = &cnt;
  assign comb[0] = integ[CIC_STAGES];

  for (genvar i = 0; i < CIC_STAGES; i++) begin : g_comb
    cic_comb #(.W(CIC_W)) u_comb (
      .clk  (clk),
      .rst  (rst),
      .ena  (dec_stb),
      .din  (comb[i]),
      .dout (comb[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cic_q <= '0;
      stb_d <= 1'b0;
    end else begin
      stb_d <= dec_stb;
      if (dec_stb)
        cic_q <= comb[CIC_STAGES];
    end
  end

  // A full-scale window yields exactly R^N, one LSB past the NL-bit range.
  assign sat = cic_q[NL] ? '1 : cic_q[NL-1:0];

  if (SHIFT >= 0) begin : g_shr
    assign scaled = sat[NL-1 -: ADC_BITLEN];
  end else begin : g_shl
    assign scaled = {sat, {(-SHIFT){1'b0}}};
  end

`ifdef SIGMA_DELTA_ADC_SETTLE_MASK_EN
  localparam int MASK_W = $clog2(CIC_STAGES + 2);
  localparam logic [MASK_W-1:0] MASK_LAST = MASK_W'(CIC_STAGES + 1);

  logic [MASK_W-1:0] mask_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mask_cnt <= '0;
    else if (stb_d && masked)
      mask_cnt <= mask_cnt + 1'b1;
  end

  assign masked = (mask_cnt != MASK_LAST);
`else
  assign masked = 1'b0;
`endif

  assign new_sample = stb_d && !masked;

  // Newest sample always wins; losing an unconsumed one latches the overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_data    <= '0;
      adc_valid   <= 1'b0;
      adc_overrun <= 1'b0;
    end else if (new_sample) begin
      adc_data  <= scaled;
      adc_valid <= 1'b1;
      if (adc_valid && !adc_ready)
        adc_overrun <= 1'b1;
    end else if (adc_valid && adc_ready) begin
      adc_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sigma_delta_adc.md
Name: sigma_delta_adc

Overview:
- Sigma-delta ADC built from FPGA fabric, plus an external RC integrator and an LVDS/comparator input pin.
- Samples the comparator bit every clk and drives the 1-bit feedback pin that closes the analog loop.
- Decimates the bitstream with an N-stage CIC (integrators at clk rate, combs at clk/OVERSAMPLE_RATE).
- Presents unsigned ADC_BITLEN samples on a valid/ready interface; acts as the capture-side counterpart of sigma_delta_dac.

Parameters:
- OVERSAMPLE_RATE, 256, decimation ratio R; must be a power of two ≥ 4.
- CIC_STAGES, 2, CIC order N (1..4).
- ADC_BITLEN, 16, output sample width.

Ports:
- clk  in  1  system clock; all logic in this single domain.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
- adc_cmp_in  in  1  raw comparator output; asynchronous to clk.
- adc_fb_pin  out  1  feedback drive to the RC network.
- adc_data  out  ADC_BITLEN  decimated sample.
- adc_valid  out  1  adc_data holds an unconsumed sample.
- adc_ready  in  1  consumer accepts adc_data when adc_valid && adc_ready.
- adc_overrun  out  1  sticky: a sample was lost to backpressure.

Behaviour:
- Reset values: adc_fb_pin=0, adc_data=0, adc_valid=0, adc_overrun=0. Synchronizer, integrators, combs and decimation counter all clear to 0.
- Input path:
  - adc_cmp_in passes through a 2-flop synchronizer, then one more register producing the bitstream bit `bs`.
  - adc_fb_pin = bs, registered, with no extra logic.
  - Latency from pin edge to adc_fb_pin is 3 clk.
- Widths:
  - L = log2(R).
  - CIC_W = N*L + 1, using unsigned modular arithmetic. Wrap-around in the integrators is intended and is cancelled by the combs.
- Integrators: N cascaded stages, each updates every clk. Stage 0 input is bs zero-extended to CIC_W.
- Decimation:
  - Counter runs 0..R-1 and wraps.
  - Strobe `dec_stb` is high on the cycle where cnt == R-1.
  - First strobe occurs R clk after rst deasserts.
- Combs: N cascaded stages, each with one delay register. They update only on dec_stb and use the last integrator output.
- Output scaling:
  - cic_out is in [0, R^N].
  - Clamp: sat = min(cic_out, R^N - 1).
  - If N*L ≥ ADC_BITLEN: adc_data = sat >> (N*L - ADC_BITLEN).
  - Otherwise: adc_data = sat << (ADC_BITLEN - N*L).
- Output handshake (registered one clk after dec_stb):
  - New sample, no valid held: load adc_data, set adc_valid=1.
  - New sample while adc_valid && !adc_ready: overwrite adc_data with the newest sample, keep adc_valid=1, set adc_overrun=1. adc_overrun stays set until reset.
  - New sample on the same cycle as a handshake (valid && ready): load the new sample, adc_valid stays 1, no overrun.
  - Handshake with no new sample: adc_valid → 0.
- Settling:
  - The first N samples after reset are CIC transients.
  - Steady value appears from output sample N+2 onward; the synchronizer delay makes the first window partial.
- Reset mid-operation: the async clear takes effect immediately, dropping any pending sample. The counter restarts, so the next strobe is R clk after deassertion.

Optional Feature:
- Macro: SIGMA_DELTA_ADC_SETTLE_MASK_EN.
- Defined: a small counter suppresses adc_valid for the first N+1 decimated samples after reset. No overrun can be flagged during the mask. The first visible sample is settled.
- Undefined: every decimated sample is presented, including transients.

Decomposition:
- Package sigma_delta_pkg holds:
  - function cic_width(R, N) returning N*$clog2(R)+1;
  - localparam helpers for L and for the output shift amount;
  - a typedef for the unsigned CIC word, parameterised through the function.
- Reuse the existing cic_integrator (ena=1) and cic_comb (ena=dec_stb) blocks at width CIC_W.
- One new sub-module, sigma_delta_sync: a 2-flop synchronizer with async active-low reset.

Test Plan:
- Defaults, adc_cmp_in held 1, adc_ready=1 → from sample 4 onward adc_data=0xFFFF (R^N=65536 clamped), adc_fb_pin=1 after 3 clk.
- adc_cmp_in held 0 → all samples 0x0000, adc_fb_pin stays 0.
- adc_cmp_in toggling every clk, phase-aligned to the window → steady adc_data=0x8000. With a 3:1 ones duty (1110 pattern) → 0xC000.
- adc_ready=0 across 2 strobes with input held 1 → adc_valid stays 1, adc_overrun=1, adc_data is the newest sample. Raising adc_ready for 1 clk → adc_valid=0, adc_overrun stays 1.
- Assert rst low mid-window (cnt≈100) for 3 clk → all outputs 0 immediately, first adc_valid exactly R+1 clk after deassertion.
- With SIGMA_DELTA_ADC_SETTLE_MASK_EN and input held 1 → first adc_valid is the (N+2)=4th strobe, value 0xFFFF.
